// File: rtl/uart_tx_fsm_if.sv
// Byte handshake between upstream logic and the UART transmitter.
// The upstream side presents valid/data; the transmitter answers with ready.
interface uart_tx_fsm_if #(
    parameter int DATA_BITS = 8
);
    logic                 valid;
    logic [DATA_BITS-1:0] data;
    logic                 ready;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/uart_tx_fsm.sv
// UART transmitter: start bit, LSB-first data, optional parity, 1 or 2 stop bits.
// All outputs are registered from next-state values so they change only on clock edges.
module uart_tx_fsm #(
    parameter int CLKS_PER_BIT = 1,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic          i_clk_rx,
    input  logic          i_reset,
    uart_tx_fsm_if.slave  host,
    output logic          o_txd,
    output logic          o_busy,
    output logic          o_done
);
    localparam int BW = $clog2(CLKS_PER_BIT) + 1;
    localparam int IW = $clog2(DATA_BITS) + 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] BIT_LAST  = IW'(DATA_BITS - 1);
    localparam logic          STOP_LAST = 1'(STOP_BITS - 1);
    localparam logic          ODD       = (PARITY_ODD != 0);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t               state_reg,  state_next;
    logic [BW-1:0]        baud_reg,   baud_next;
    logic [IW-1:0]        bit_reg,    bit_next;
    logic                 stop_reg,   stop_next;
    logic [DATA_BITS-1:0] shift_reg,  shift_next;
    logic                 parity_reg, parity_next;
    logic                 txd_reg,    txd_next;
    logic                 ready_reg,  ready_next;
    logic                 done_reg,   done_next;
    logic                 bit_end;

    always_ff @(posedge i_clk_rx or negedge i_reset) begin
        if (!i_reset) begin
            state_reg  <= S_IDLE;
            baud_reg   <= '0;
            bit_reg    <= '0;
            stop_reg   <= 1'b0;
            shift_reg  <= '0;
            parity_reg <= 1'b0;
            txd_reg    <= 1'b1;
            ready_reg  <= 1'b1;
            done_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            baud_reg   <= baud_next;
            bit_reg    <= bit_next;
            stop_reg   <= stop_next;
            shift_reg  <= shift_next;
            parity_reg <= parity_next;
            txd_reg    <= txd_next;
            ready_reg  <= ready_next;
            done_reg   <= done_next;
        end
    end

    assign bit_end = (baud_reg == BAUD_LAST);

    always_comb begin
        state_next  = state_reg;
        baud_next   = baud_reg;
        bit_next    = bit_reg;
        stop_next   = stop_reg;
        shift_next  = shift_reg;
        parity_next = parity_reg;

        case (state_reg)
            S_IDLE: begin
                baud_next = '0;
                bit_next  = '0;
                stop_next = 1'b0;
                if (host.valid) begin
                    shift_next  = host.data;
                    parity_next = (^host.data) ^ ODD;
                    state_next  = S_START;
                end
            end
            S_START: begin
                if (bit_end) begin
                    baud_next  = '0;
                    state_next = S_DATA;
                end else begin
                    baud_next = baud_reg + 1'b1;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    baud_next  = '0;
                    shift_next = shift_reg >> 1;
                    if (bit_reg == BIT_LAST) begin
                        bit_next   = '0;
                        state_next = (PARITY_EN != 0) ? S_PARITY : S_STOP;
                    end else begin
                        bit_next = bit_reg + 1'b1;
                    end
                end else begin
                    baud_next = baud_reg + 1'b1;
                end
            end
            S_PARITY: begin
                if (bit_end) begin
                    baud_next  = '0;
                    state_next = S_STOP;
                end else begin
                    baud_next = baud_reg + 1'b1;
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    baud_next = '0;
                    if (stop_reg == STOP_LAST) begin
                        stop_next  = 1'b0;
                        state_next = S_IDLE;
                    end else begin
                        stop_next = 1'b1;
                    end
                end else begin
                    baud_next = baud_reg + 1'b1;
                end
            end
            default: begin
                state_next = S_IDLE;
                baud_next  = '0;
                bit_next   = '0;
                stop_next  = 1'b0;
            end
        endcase
    end

    // Line level and flags follow the state being entered, giving one-cycle start latency.
    always_comb begin
        txd_next   = 1'b1;
        ready_next = (state_next == S_IDLE);
        done_next  = (state_next == S_STOP) && (baud_next == BAUD_LAST)
                     && (stop_next == STOP_LAST);
        case (state_next)
            S_START:  txd_next = 1'b0;
            S_DATA:   txd_next = shift_next[0];
            S_PARITY: txd_next = parity_next;
            default:  txd_next = 1'b1;
        endcase
    end

    assign host.ready = ready_reg;
    assign o_busy     = ~ready_reg;
    assign o_txd      = txd_reg;
    assign o_done     = done_reg;
endmodule

// File: tb/tb_uart_tx_fsm.sv
// Directed bench for uart_tx_fsm: four configurations sharing clock and reset,
// each frame checked cycle by cycle against hand-derived bit sequences.
module tb_uart_tx_fsm;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] txd_w, busy_w, done_w, ready_w;
    int         n_tests = 0;
    int         n_fail  = 0;

    always #5 clk = ~clk;

    uart_tx_fsm_if #(.DATA_BITS(8)) if0 ();
    uart_tx_fsm_if #(.DATA_BITS(8)) if1 ();
    uart_tx_fsm_if #(.DATA_BITS(8)) if2 ();
    uart_tx_fsm_if #(.DATA_BITS(8)) if3 ();

    assign ready_w = {if3.ready, if2.ready, if1.ready, if0.ready};

    uart_tx_fsm d0 (.i_clk_rx(clk), .i_reset(rst_n), .host(if0.slave),
                    .o_txd(txd_w[0]), .o_busy(busy_w[0]), .o_done(done_w[0]));
    uart_tx_fsm #(.PARITY_EN(1), .PARITY_ODD(0)) d1 (.i_clk_rx(clk), .i_reset(rst_n),
                    .host(if1.slave), .o_txd(txd_w[1]), .o_busy(busy_w[1]), .o_done(done_w[1]));
    uart_tx_fsm #(.PARITY_EN(1), .PARITY_ODD(1)) d2 (.i_clk_rx(clk), .i_reset(rst_n),
                    .host(if2.slave), .o_txd(txd_w[2]), .o_busy(busy_w[2]), .o_done(done_w[2]));
    uart_tx_fsm #(.CLKS_PER_BIT(4), .STOP_BITS(2)) d3 (.i_clk_rx(clk), .i_reset(rst_n),
                    .host(if3.slave), .o_txd(txd_w[3]), .o_busy(busy_w[3]), .o_done(done_w[3]));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_in(input int k, input logic v, input logic [7:0] d);
        case (k)
            0: begin if0.valid = v; if0.data = d; end
            1: begin if1.valid = v; if1.data = d; end
            2: begin if2.valid = v; if2.data = d; end
            default: begin if3.valid = v; if3.data = d; end
        endcase
    endtask

    // Expected line level in cycle c (1-based) of a frame.
    function automatic logic exp_bit(input logic [7:0] d, input int c, input int cpb,
                                     input int par_en, input logic par_bit);
        int b;
        logic [7:0] dv;
        dv = d;
        b = (c - 1) / cpb;
        if (b == 0) return 1'b0;
        if (b <= 8) return dv[b-1];
        if (par_en != 0 && b == 9) return par_bit;
        return 1'b1;
    endfunction

    task automatic run_frame(input int k, input logic [7:0] d, input int cpb, input int par_en,
                             input logic par_bit, input int stops, input string name);
        int n;
        n = cpb * (1 + 8 + par_en + stops);
        @(negedge clk);
        check($sformatf("%s_ready_pre", name), ready_w[k], 1);
        set_in(k, 1'b1, d);
        @(posedge clk);
        for (int c = 1; c <= n; c++) begin
            @(negedge clk);
            if (c == 1) set_in(k, 1'b0, ~d);
            check($sformatf("%s_txd_c%0d", name, c), txd_w[k], exp_bit(d, c, cpb, par_en, par_bit));
            check($sformatf("%s_done_c%0d", name, c), done_w[k], (c == n));
            if (c == 1 || c == n) begin
                check($sformatf("%s_busy_c%0d", name, c), busy_w[k], 1);
                check($sformatf("%s_ready_c%0d", name, c), ready_w[k], 0);
            end
        end
        @(negedge clk);
        check($sformatf("%s_ready_end", name), ready_w[k], 1);
        check($sformatf("%s_txd_end", name), txd_w[k], 1);
        check($sformatf("%s_done_end", name), done_w[k], 0);
        $display("[TB] %s: inst %0d sent 0x%02h in %0d cycles", name, k, d, n);
    endtask

    task automatic mid_reset(input logic [7:0] d);
        @(negedge clk);
        set_in(0, 1'b1, d);
        @(posedge clk);
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            if (c == 1) set_in(0, 1'b0, 8'h00);
            check($sformatf("rst_%02h_txd_c%0d", d, c), txd_w[0], exp_bit(d, c, 1, 0, 1'b0));
        end
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_txd", txd_w[0], 1);
        check("mid_rst_ready", ready_w[0], 1);
        check("mid_rst_busy", busy_w[0], 0);
        check("mid_rst_done", done_w[0], 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check($sformatf("post_rst_idle_c%0d", c), {txd_w[0], ready_w[0], done_w[0]}, 3'b110);
        end
        $display("[TB] mid-frame reset during 0x%02h bit 3", d);
    endtask

    initial begin
        rst_n = 1'b0;
        for (int k = 0; k < 4; k++) set_in(k, 1'b1, 8'hA5);

        // Reset held with valid asserted: everything stays idle.
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            for (int k = 0; k < 4; k++) begin
                check($sformatf("rst_i%0d_c%0d", k, c),
                      {txd_w[k], ready_w[k], busy_w[k], done_w[k]}, 4'b1100);
            end
        end
        for (int k = 0; k < 4; k++) set_in(k, 1'b0, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        $display("[TB] reset hold checked");

        run_frame(0, 8'hA5, 1, 0, 1'b0, 1, "basic_a5");
        run_frame(0, 8'h00, 1, 0, 1'b0, 1, "basic_00");
        run_frame(1, 8'hA5, 1, 1, 1'b0, 1, "par_even_a5");
        run_frame(2, 8'hA5, 1, 1, 1'b1, 1, "par_odd_a5");
        run_frame(1, 8'h07, 1, 1, 1'b1, 1, "par_even_07");
        run_frame(3, 8'h3C, 4, 0, 1'b0, 2, "os4_stop2_3c");

        // Handshake: valid held high across two bytes.
        @(negedge clk);
        set_in(0, 1'b1, 8'h11);
        @(posedge clk);
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (c == 1) begin
                set_in(0, 1'b1, 8'h22);
                check("hs_ready_busy", ready_w[0], 0);
            end
            check($sformatf("hs_11_txd_c%0d", c), txd_w[0], exp_bit(8'h11, c, 1, 0, 1'b0));
            check($sformatf("hs_11_done_c%0d", c), done_w[0], (c == 10));
        end
        @(negedge clk);
        check("hs_gap_ready", ready_w[0], 1);
        check("hs_gap_txd", txd_w[0], 1);
        @(posedge clk);
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (c == 1) set_in(0, 1'b0, 8'h00);
            check($sformatf("hs_22_txd_c%0d", c), txd_w[0], exp_bit(8'h22, c, 1, 0, 1'b0));
            check($sformatf("hs_22_done_c%0d", c), done_w[0], (c == 10));
        end
        @(negedge clk);
        check("hs_end_ready", ready_w[0], 1);
        $display("[TB] handshake 0x11 then 0x22 checked");

        mid_reset(8'hFF);
        run_frame(0, 8'h55, 1, 0, 1'b0, 1, "after_rst_55");
        mid_reset(8'h00);
        run_frame(0, 8'h55, 1, 0, 1'b0, 1, "after_rst2_55");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
